// File: rtl/demux_pkg.sv
// Shared definitions for the demux scheduler/serializer slice: channel
// count, select width, FSM state encoding and the channel-index type.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Bit 0 is the MSB, matching the demux select bit order.
    typedef logic [0:SEL_W-1] ch_t;

endpackage

// File: rtl/demux_sched_serializer_if.sv
// Request handshake between a word producer and the serializer.
// master drives the request; slave (the serializer) returns ready.
interface demux_sched_serializer_if #(
    parameter int DATA_W = 8
);

    logic                req_valid;
    logic                req_ready;
    demux_pkg::ch_t      req_dest;
    logic [DATA_W-1:0]   req_data;

    modport master (
        output req_valid,
        output req_dest,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/demux_sched_piso.sv
// DATA_W-bit parallel-load, MSB-first shift register with a beat counter.
// Zeros are shifted in, so after a full word the register is empty and the
// serial output rests low without extra gating.
module demux_sched_piso #(
    parameter  int DATA_W = 8,
    localparam int BEAT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_out,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    // Next shift-register contents and beat count from the load/shift strobes.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d; otherwise a latch is inferred.
        sreg_d = sreg_q;
        beat_d = beat_q;
        if (load) begin
            sreg_d = load_data;
            beat_d = '0;
        end else if (shift) begin
            sreg_d = sreg_q << 1;
            beat_d = beat_q + 1'b1;
        end
    end

    // Register the shift chain and beat counter; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            sreg_q <= '0;
            beat_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            beat_q <= beat_d;
        end
    end

    assign ser_out = sreg_q[DATA_W-1];
    assign beat    = beat_q;
    assign last    = (beat_q == BEAT_W'(DATA_W - 1));

endmodule

// File: rtl/demux_sched_serializer.sv
// Upstream feeder for a 1-to-8 single-bit demux: accepts a tagged word,
// holds the select, shifts the word out MSB-first, then inserts a guard
// gap with data low so a select change never meets a high data bit.
// Optional per-channel word counters: define DEMUX_SCHED_STATS_EN.
module demux_sched_serializer
    import demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    demux_sched_serializer_if.slave    req,
    output logic                       dmx_in,
    output ch_t                        dmx_sel,
    output logic                       busy,
    output logic                       done,
    input  ch_t                        stat_ch,
    output logic [CNT_W-1:0]           stat_cnt
);

    localparam int BEAT_W = $clog2(DATA_W + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t             state_q, state_d;
    ch_t                sel_q,   sel_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;

    logic               accept;
    logic [BEAT_W-1:0]  beat;
    logic               last;

    // ready is only ever high in IDLE, so an accept implies IDLE.
    assign accept = req.req_valid && ready_q;

    demux_sched_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .shift     (state_q == SHIFT),
        .load_data (req.req_data),
        .ser_out   (dmx_in),
        .beat      (beat),
        .last      (last)
    );

    // FSM next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sel_d   = req.req_dest;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = (DATA_W == 1);
                end
            end
            SHIFT: begin
                if (last) begin
                    gap_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    // done lines up with the final beat on dmx_in.
                    done_d = (int'(beat) == DATA_W - 2);
                end
            end
            GAP: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; a reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
        end
    end

    assign req.req_ready = ready_q;
    assign dmx_sel       = sel_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    // Count completed words on the channel currently selected.
    always_comb begin
        cnt_d = cnt_q;
        if (done_q) begin
            cnt_d[dmx_sel] = cnt_q[dmx_sel] + 1'b1;
        end
    end

    // Counter bank register; cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this array is a register file, not RAM, so it is reset explicitly to start counts at zero.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q[stat_ch];
`else
    logic unused_stat_ch;
    assign unused_stat_ch = ^stat_ch;
    assign stat_cnt       = '0;
`endif

endmodule

// File: tb/tb_demux_sched_serializer.sv
// Bench for demux_sched_serializer: two instances (DATA_W=8/GAP=1/CNT_W=16
// and DATA_W=1/GAP=0/CNT_W=2) run in lockstep against a timeline model that
// derives every output from the cycle of the last accepted word.
module tb_demux_sched_serializer;
    import demux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Per-instance drive values (applied) and next values (set by stimulus).
    logic        drv_rst   [2];
    logic        drv_valid [2];
    ch_t         drv_dest  [2];
    logic [7:0]  drv_data  [2];
    ch_t         drv_stat  [2];
    logic        nxt_rst   [2];
    logic        nxt_valid [2];
    ch_t         nxt_dest  [2];
    logic [7:0]  nxt_data  [2];
    ch_t         nxt_stat  [2];

    logic        obs_in    [2];
    ch_t         obs_sel   [2];
    logic        obs_busy  [2];
    logic        obs_done  [2];
    logic        obs_ready [2];
    logic [15:0] obs_stat  [2];

    // Instance A: default parameters.
    demux_sched_serializer_if #(.DATA_W(8)) if_a ();
    logic        in_a, busy_a, done_a;
    ch_t         sel_a;
    logic [15:0] scnt_a;
    assign if_a.req_valid = drv_valid[0];
    assign if_a.req_dest  = drv_dest[0];
    assign if_a.req_data  = drv_data[0];

    demux_sched_serializer #(.DATA_W(8), .GAP_CYCLES(1), .CNT_W(16)) dut_a (
        .clk      (clk),
        .rst_n    (drv_rst[0]),
        .req      (if_a.slave),
        .dmx_in   (in_a),
        .dmx_sel  (sel_a),
        .busy     (busy_a),
        .done     (done_a),
        .stat_ch  (drv_stat[0]),
        .stat_cnt (scnt_a)
    );

    // Instance B: one-bit words, no gap, two-bit counters.
    demux_sched_serializer_if #(.DATA_W(1)) if_b ();
    logic        in_b, busy_b, done_b;
    ch_t         sel_b;
    logic [1:0]  scnt_b;
    assign if_b.req_valid = drv_valid[1];
    assign if_b.req_dest  = drv_dest[1];
    assign if_b.req_data  = drv_data[1][0:0];

    demux_sched_serializer #(.DATA_W(1), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
        .clk      (clk),
        .rst_n    (drv_rst[1]),
        .req      (if_b.slave),
        .dmx_in   (in_b),
        .dmx_sel  (sel_b),
        .busy     (busy_b),
        .done     (done_b),
        .stat_ch  (drv_stat[1]),
        .stat_cnt (scnt_b)
    );

    assign obs_in[0]    = in_a;
    assign obs_sel[0]   = sel_a;
    assign obs_busy[0]  = busy_a;
    assign obs_done[0]  = done_a;
    assign obs_ready[0] = if_a.req_ready;
    assign obs_stat[0]  = scnt_a;
    assign obs_in[1]    = in_b;
    assign obs_sel[1]   = sel_b;
    assign obs_busy[1]  = busy_b;
    assign obs_done[1]  = done_b;
    assign obs_ready[1] = if_b.req_ready;
    assign obs_stat[1]  = {14'b0, scnt_b};

    // ---------------- reference model ----------------
    int         acc_cyc [2];
    logic [7:0] mword   [2];
    int         msel    [2];
    int         mcnt    [2][8];

    function automatic int dw_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction
    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction
    function automatic int cw_of(input int i);
        return (i == 0) ? 16 : 2;
    endfunction
    function automatic int off_of(input int i);
        return cyc - acc_cyc[i];
    endfunction
    function automatic bit exp_busy(input int i);
        int o = off_of(i);
        return (o >= 1) && (o <= dw_of(i) + gap_of(i));
    endfunction
    function automatic bit exp_in(input int i);
        int o = off_of(i);
        if (o >= 1 && o <= dw_of(i)) return mword[i][dw_of(i) - o];
        return 1'b0;
    endfunction
    function automatic bit exp_done(input int i);
        return off_of(i) == dw_of(i);
    endfunction
    function automatic int exp_stat(input int i);
`ifdef DEMUX_SCHED_STATS_EN
        return mcnt[i][drv_stat[i]];
`else
        return 0;
`endif
    endfunction

    task automatic model_reset(input int i);
        acc_cyc[i] = -1000;
        msel[i]    = 0;
        for (int c = 0; c < 8; c++) mcnt[i][c] = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input int i);
        string p;
        p = $sformatf("cyc%0d dut%0d", cyc, i);
        check({p, " ready"}, obs_ready[i], !exp_busy(i));
        check({p, " busy"},  obs_busy[i],  exp_busy(i));
        check({p, " done"},  obs_done[i],  exp_done(i));
        check({p, " dmx_in"}, obs_in[i],   exp_in(i));
        check({p, " dmx_sel"}, obs_sel[i], msel[i]);
        check({p, " stat"},  obs_stat[i],  exp_stat(i));
        check({p, " excl"},  obs_ready[i] & obs_busy[i], 0);
    endtask

    // Check the current cycle, then apply the next-values as this cycle's inputs.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            check_dut(i);
            if (exp_done(i)) mcnt[i][msel[i]] = (mcnt[i][msel[i]] + 1) % (1 << cw_of(i));
        end
        for (int i = 0; i < 2; i++) begin
            if (!nxt_rst[i]) begin
                model_reset(i);
            end else if (nxt_valid[i] && !exp_busy(i)) begin
                acc_cyc[i] = cyc;
                mword[i]   = nxt_data[i];
                msel[i]    = int'(nxt_dest[i]);
            end
            drv_rst[i]   = nxt_rst[i];
            drv_valid[i] = nxt_valid[i];
            drv_dest[i]  = nxt_dest[i];
            drv_data[i]  = nxt_data[i];
            drv_stat[i]  = nxt_stat[i];
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        nxt_valid[0] = 1'b0;
        nxt_valid[1] = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int i, input int dest, input logic [7:0] data);
        nxt_valid[i] = 1'b1;
        nxt_dest[i]  = ch_t'(dest);
        nxt_data[i]  = data;
        tick();
        nxt_valid[i] = 1'b0;
        for (int k = 0; k < dw_of(i) + gap_of(i); k++) tick();
    endtask

    task automatic stat_sweep();
        for (int c = 0; c < 8; c++) begin
            nxt_stat[0] = ch_t'(c);
            nxt_stat[1] = ch_t'(c);
            tick();
        end
    endtask

    logic [7:0] seq;
    int         first_cyc, dcount;
    bit         found, prev_in;
    int         exp_a4, exp_a0, exp_b4;

    initial begin
        for (int i = 0; i < 2; i++) begin
            nxt_rst[i] = 1'b1; nxt_valid[i] = 1'b0; nxt_dest[i] = '0;
            nxt_data[i] = '0;  nxt_stat[i] = '0;
            drv_rst[i] = 1'b0; drv_valid[i] = 1'b0; drv_dest[i] = '0;
            drv_data[i] = '0;  drv_stat[i] = '0;
            model_reset(i);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idle(2);

        // Word A5 to channel 5: MSB first, done on the 8th bit, one gap cycle.
        nxt_valid[0] = 1'b1; nxt_dest[0] = ch_t'(5); nxt_data[0] = 8'hA5;
        tick();
        nxt_valid[0] = 1'b0;
        check("t1 sel", obs_sel[0], 5);
        for (int k = 0; k < 8; k++) begin
            seq[7-k] = obs_in[0];
            if (k == 7) check("t1 done", obs_done[0], 1);
            tick();
        end
        check("t1 seq", seq, 8'hA5);
        check("t1 gap ready", obs_ready[0], 0);
        check("t1 gap in", obs_in[0], 0);
        tick();
        check("t1 ready back", obs_ready[0], 1);

        // Back-to-back with valid held: select changes only at the second accept.
        nxt_valid[0] = 1'b1; nxt_dest[0] = ch_t'(2); nxt_data[0] = 8'hFF;
        tick();
        nxt_dest[0] = ch_t'(6); nxt_data[0] = 8'h81;
        first_cyc = cyc;
        check("t2 sel first", obs_sel[0], 2);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            prev_in = obs_in[0];
            tick();
            if (obs_sel[0] == ch_t'(6)) begin
                found = 1'b1;
                check("t2 spacing", cyc - first_cyc, 10);
                check("t2 low before change", prev_in, 0);
            end
        end
        check("t2 second accept seen", found, 1);
        idle(12);

        // Reset at beat 3 of F0 to channel 7: abort, no done, no count.
        nxt_valid[0] = 1'b1; nxt_dest[0] = ch_t'(7); nxt_data[0] = 8'hF0;
        tick();
        nxt_valid[0] = 1'b0;
        tick(); tick(); tick();
        nxt_rst[0] = 1'b0;
        tick();
        nxt_rst[0] = 1'b1;
        check("t3 busy", obs_busy[0], 0);
        check("t3 sel", obs_sel[0], 0);
        check("t3 in", obs_in[0], 0);
        check("t3 done", obs_done[0], 0);
        nxt_stat[0] = ch_t'(7);
        tick(); tick();
        check("t3 stat7", obs_stat[0], 0);
        idle(4);

        // One-bit words, no gap: 1 then 0 to channel 3 with an IDLE cycle between.
        nxt_valid[1] = 1'b1; nxt_dest[1] = ch_t'(3); nxt_data[1] = 8'h01;
        tick();
        check("t4 bit1", obs_in[1], 1);
        check("t4 done1", obs_done[1], 1);
        nxt_data[1] = 8'h00;
        tick();
        check("t4 idle in", obs_in[1], 0);
        check("t4 idle ready", obs_ready[1], 1);
        tick();
        nxt_valid[1] = 1'b0;
        check("t4 bit0", obs_in[1], 0);
        check("t4 done0", obs_done[1], 1);
        check("t4 sel", obs_sel[1], 3);
        idle(3);

        // Per-channel counters, including the two-bit wrap on instance B.
        for (int k = 0; k < 3; k++) send(0, 4, 8'($urandom));
        send(0, 0, 8'($urandom));
        for (int k = 0; k < 5; k++) send(1, 4, 8'($urandom));
`ifdef DEMUX_SCHED_STATS_EN
        exp_a4 = 3; exp_a0 = 1; exp_b4 = 1;
`else
        exp_a4 = 0; exp_a0 = 0; exp_b4 = 0;
`endif
        nxt_stat[0] = ch_t'(4); nxt_stat[1] = ch_t'(4);
        tick(); tick();
        check("t5 a ch4", obs_stat[0], exp_a4);
        check("t5 b ch4", obs_stat[1], exp_b4);
        nxt_stat[0] = ch_t'(0);
        tick(); tick();
        check("t5 a ch0", obs_stat[0], exp_a0);
        stat_sweep();

        // Random traffic: junk on request lines while busy, sporadic resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                nxt_rst[i]   = ($urandom_range(0, 79) != 0);
                nxt_valid[i] = 1'($urandom_range(0, 1));
                nxt_dest[i]  = ch_t'($urandom_range(0, 7));
                nxt_data[i]  = 8'($urandom);
                nxt_stat[i]  = ch_t'($urandom_range(0, 7));
            end
            tick();
        end
        nxt_rst[0] = 1'b1; nxt_rst[1] = 1'b1;
        idle(12);
        stat_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
